// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor command packer.
// Word layout: [12]=direction, [11]=change, [10:0]=speed.
package motor_pkg;

   localparam int DEF_DATA_W = 11;
   localparam int DEF_WORD_W = DEF_DATA_W + 2;
   localparam int DIR_BIT    = 12;
   localparam int CHG_BIT    = 11;

   typedef enum logic [1:0] {
      IDLE,
      STOP,
      HOLD
   } state_e;

   function automatic logic [DEF_WORD_W-1:0] pack_word(
      input logic                  dir,
      input logic                  chg,
      input logic [DEF_DATA_W-1:0] spd
   );
      logic [DEF_WORD_W-1:0] w;
      w                   = '0;
      w[DIR_BIT]          = dir;
      w[CHG_BIT]          = chg;
      w[DEF_DATA_W-1:0]   = spd;
      return w;
   endfunction

endpackage

// File: rtl/motor_cmd_packer_if.sv
// Command handshake from the STM32 command path into the packer.
// Master drives the command, slave answers with ready.
interface motor_cmd_if #(
   parameter int DATA_W = 11
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_direction;
   logic [DATA_W-1:0] cmd_speed;

   modport master (
      output cmd_valid,
      output cmd_direction,
      output cmd_speed,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_direction,
      input  cmd_speed,
      output cmd_ready
   );

endinterface

// File: rtl/motor_hold_timer.sv
// Loadable down-counter shared by the STOP and HOLD dwell phases.
// Saturates at zero; done is high while the count is zero.
module motor_hold_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/motor_cmd_packer.sv
// Packs direction/speed commands into motor words, with change bit,
// minimum hold time and a stop word before reversal at speed.
module motor_cmd_packer
   import motor_pkg::*;
#(
   parameter int DATA_W      = 11,
   parameter int HOLD_CYCLES = 4,
   parameter int STOP_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   motor_cmd_if.slave        cmd,
   output logic [DATA_W+1:0] word_out,
   output logic              word_strobe,
   output logic              busy
);

   localparam int CNT_MAX = (HOLD_CYCLES > STOP_CYCLES) ?
                            HOLD_CYCLES : STOP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STOP_LD = CNT_W'(STOP_CYCLES - 1);

   state_e              state_q, state_d;
   logic [DATA_W+1:0]   word_q, word_d;
   logic                strobe_q, strobe_d;
   logic                last_dir_q, last_dir_d;
   logic [DATA_W-1:0]   last_spd_q, last_spd_d;
   logic                lat_dir_q, lat_dir_d;
   logic [DATA_W-1:0]   lat_spd_q, lat_spd_d;

   logic                accept;
   logic                dup;
   logic                rev;
   logic                tmr_load;
   logic [CNT_W-1:0]    tmr_val;
   logic                tmr_done;

   assign cmd.cmd_ready = (state_q == IDLE) & ~reset;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;

   assign dup = (cmd.cmd_direction == last_dir_q) &&
                (cmd.cmd_speed == last_spd_q);
   assign rev = (cmd.cmd_direction != last_dir_q) &&
                (last_spd_q != '0) &&
                (cmd.cmd_speed != '0);

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      strobe_d   = 1'b0;
      last_dir_d = last_dir_q;
      last_spd_d = last_spd_q;
      lat_dir_d  = lat_dir_q;
      lat_spd_d  = lat_spd_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  dup: begin
                  end
                  rev: begin
                     // Park at zero speed in the old direction first
                     word_d    = {last_dir_q, 1'b0, {DATA_W{1'b0}}};
                     strobe_d  = 1'b1;
                     lat_dir_d = cmd.cmd_direction;
                     lat_spd_d = cmd.cmd_speed;
                     tmr_load  = 1'b1;
                     tmr_val   = STOP_LD;
                     state_d   = STOP;
                  end
                  default: begin
                     word_d     = {cmd.cmd_direction,
                                   cmd.cmd_direction != last_dir_q,
                                   cmd.cmd_speed};
                     strobe_d   = 1'b1;
                     last_dir_d = cmd.cmd_direction;
                     last_spd_d = cmd.cmd_speed;
                     tmr_load   = 1'b1;
                     tmr_val    = HOLD_LD;
                     state_d    = HOLD;
                  end
               endcase
            end
         end
         STOP: begin
            if (tmr_done) begin
               word_d     = {lat_dir_q, 1'b1, lat_spd_q};
               strobe_d   = 1'b1;
               last_dir_d = lat_dir_q;
               last_spd_d = lat_spd_q;
               tmr_load   = 1'b1;
               tmr_val    = HOLD_LD;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (tmr_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         word_q     <= '0;
         strobe_q   <= 1'b0;
         last_dir_q <= 1'b0;
         last_spd_q <= '0;
         lat_dir_q  <= 1'b0;
         lat_spd_q  <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         strobe_q   <= strobe_d;
         last_dir_q <= last_dir_d;
         last_spd_q <= last_spd_d;
         lat_dir_q  <= lat_dir_d;
         lat_spd_q  <= lat_spd_d;
      end
   end

   motor_hold_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign word_out    = word_q;
   assign word_strobe = strobe_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_motor_cmd_packer.sv
// Scoreboard bench for motor_cmd_packer.
// Expected words are queued at drive time and popped on each strobe.
module tb_motor_cmd_packer;
   import motor_pkg::*;

   localparam int DW = 11;

   logic          clk;
   logic          reset;
   logic [DW+1:0] word_out;
   logic          word_strobe;
   logic          busy;

   motor_cmd_if #(.DATA_W(DW)) cif ();

   motor_cmd_packer #(
      .DATA_W      (DW),
      .HOLD_CYCLES (4),
      .STOP_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (cif),
      .word_out    (word_out),
      .word_strobe (word_strobe),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_cmp;
   int            n_err;
   int            n_strb;
   logic [DW+1:0] exp_q[$];
   logic          m_dir;
   logic [DW-1:0] m_spd;
   logic          rst_seen;
   logic          prev_strb;
   logic [DW+1:0] prev_word;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) rst_seen <= reset;

   // Output monitor: scoreboard pop plus strobe/word invariants
   always @(negedge clk) begin
      if (word_strobe) begin
         n_strb++;
         chk("strobe_gap", {31'd0, prev_strb}, 32'd0);
         chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            chk("sb_word", {19'd0, word_out},
                {19'd0, exp_q.pop_front()});
         end
      end else if (!rst_seen && prev_word !== word_out) begin
         chk("word_hold", {19'd0, word_out}, {19'd0, prev_word});
      end
      prev_strb = word_strobe;
      prev_word = word_out;
   end

   task automatic model_push(input logic d, input logic [DW-1:0] s);
      if (d == m_dir && s == m_spd) begin
         return;
      end
      if (d != m_dir && m_spd != '0 && s != '0) begin
         exp_q.push_back(pack_word(m_dir, 1'b0, '0));
         exp_q.push_back(pack_word(d, 1'b1, s));
      end else begin
         exp_q.push_back(pack_word(d, d != m_dir, s));
      end
      m_dir = d;
      m_spd = s;
   endtask

   // Called at a negedge; returns #1 after the accepting posedge
   task automatic send(input logic d, input logic [DW-1:0] s);
      int n;
      cif.cmd_valid     = 1'b1;
      cif.cmd_direction = d;
      cif.cmd_speed     = s;
      n = 0;
      while (!cif.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cif.cmd_ready) begin
         chk("ready_timeout", {31'd0, cif.cmd_ready}, 32'd1);
         cif.cmd_valid = 1'b0;
         return;
      end
      model_push(d, s);
      @(posedge clk);
      #1;
      cif.cmd_valid = 1'b0;
   endtask

   // At the strobe-cycle negedge: ready low 4 cycles, high at T+4
   task automatic hold_chk();
      chk("ready_T0", {31'd0, cif.cmd_ready}, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("ready_hold", {31'd0, cif.cmd_ready},
             {31'd0, i == 4});
      end
   endtask

   initial begin
      int n0;
      n_cmp = 0;
      n_err = 0;
      n_strb = 0;
      m_dir = 1'b0;
      m_spd = '0;
      prev_strb = 1'b0;
      prev_word = '0;
      reset = 1'b1;
      cif.cmd_valid = 1'b0;
      cif.cmd_direction = 1'b0;
      cif.cmd_speed = '0;

      // 1: reset
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_word", {19'd0, word_out}, 32'd0);
         chk("rst_strb", {31'd0, word_strobe}, 32'd0);
         chk("rst_ready", {31'd0, cif.cmd_ready}, 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      chk("ready_post_rst", {31'd0, cif.cmd_ready}, 32'd1);
      chk("busy_idle", {31'd0, busy}, 32'd0);

      // 2: first command
      send(1'b1, 11'b10101000101);
      @(negedge clk);
      chk("t2_strb", {31'd0, word_strobe}, 32'd1);
      chk("t2_word", {19'd0, word_out}, {19'd0, 13'b1110101000101});
      hold_chk();

      // 3: same direction, new speed
      send(1'b1, 11'h100);
      @(negedge clk);
      chk("t3_word", {19'd0, word_out}, {19'd0, 13'b1000100000000});
      hold_chk();

      // 4: reversal at speed
      n0 = n_strb;
      send(1'b0, 11'b10101000101);
      @(negedge clk);
      chk("t4_stop", {19'd0, word_out}, {19'd0, 13'b1000000000000});
      chk("t4_busy", {31'd0, busy}, 32'd1);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("t4_dwell_strb", {31'd0, word_strobe}, 32'd0);
         chk("t4_dwell_word", {19'd0, word_out},
             {19'd0, 13'b1000000000000});
      end
      @(negedge clk);
      chk("t4_post_strb", {31'd0, word_strobe}, 32'd1);
      chk("t4_post_word", {19'd0, word_out},
          {19'd0, 13'b0110101000101});
      hold_chk();
      chk("t4_nstrb", n_strb - n0, 32'd2);

      // 5: duplicate is accepted and dropped
      n0 = n_strb;
      send(1'b0, 11'b10101000101);
      @(negedge clk);
      chk("t5_ready", {31'd0, cif.cmd_ready}, 32'd1);
      repeat (3) @(negedge clk);
      chk("t5_nstrb", n_strb - n0, 32'd0);
      chk("t5_word", {19'd0, word_out}, {19'd0, 13'b0110101000101});

      // Zero-speed reversal goes straight out with change set
      send(1'b1, 11'd0);
      @(negedge clk);
      chk("z_word", {19'd0, word_out}, {19'd0, 13'h1800});
      hold_chk();
      send(1'b0, 11'h7FF);
      @(negedge clk);
      chk("z2_word", {19'd0, word_out}, {19'd0, 13'h0FFF});
      hold_chk();

      // 6: reset on the third cycle of STOP
      send(1'b1, 11'h0AB);
      @(negedge clk);
      chk("t6_stop_strb", {31'd0, word_strobe}, 32'd1);
      chk("t6_stop_word", {19'd0, word_out}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      m_dir = 1'b0;
      m_spd = '0;
      @(negedge clk);
      chk("t6_word", {19'd0, word_out}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_strb", {31'd0, word_strobe}, 32'd0);
      reset = 1'b0;
      n0 = n_strb;
      repeat (12) @(negedge clk);
      chk("t6_nstrb", n_strb - n0, 32'd0);
      chk("t6_ready", {31'd0, cif.cmd_ready}, 32'd1);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/motor_cmd_packer.md
Name: motor_cmd_packer

Overview:
Transmit-side counterpart of the motor register. It accepts motor commands (direction plus 11-bit pulse data) from the STM32 command path over a valid/ready handshake. It packs each command into the 13-bit motor word and drives that word into the motor register. It generates the change bit, enforces a minimum hold time per word, and inserts a zero-speed stop word before any direction reversal at speed.

Parameters:
DATA_W, 11, width of pulse/speed field
HOLD_CYCLES, 4, cycles each emitted word is held before the next command is accepted (min 1)
STOP_CYCLES, 8, dwell cycles of the inserted stop word on reversal (min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  packer can accept a command this cycle
cmd_direction  input  1  requested direction
cmd_speed  input  DATA_W  requested pulse data
word_out  output  DATA_W+2  packed word to motor register data_in: [12]=direction, [11]=change, [10:0]=speed
word_strobe  output  1  one-cycle pulse on the cycle word_out takes a new value
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset, on a clk edge with reset=1:
  - word_out=0, word_strobe=0, state=IDLE.
  - cmd_ready=0 while reset is high; cmd_ready=1 from the first cycle after release.
  - Stored last direction=0, last speed=0. Counter=0.
- Handshake: a command is accepted only when cmd_valid & cmd_ready are high at a rising edge.
  - cmd_ready = (state==IDLE) & ~reset.
- States: IDLE, STOP, HOLD.
- IDLE, command accepted:
  - Duplicate command (same direction and same speed as last): dropped. No strobe; remain in IDLE.
  - Reversal at speed (direction differs, last speed!=0, new speed!=0):
    - Next cycle: word_out={last_dir,0,0}, strobe=1.
    - Enter STOP; command latched internally.
  - Otherwise:
    - Next cycle: word_out={new_dir, (new_dir!=last_dir), new_speed}, strobe=1.
    - Last dir/speed updated; enter HOLD.
- STOP: hold the stop word for STOP_CYCLES cycles, counting from the strobe cycle. Then:
  - Emit word_out={latched_dir,1,latched_speed}, strobe=1.
  - Update last dir/speed; enter HOLD.
- HOLD: hold word_out for HOLD_CYCLES cycles, counting from the strobe cycle, then return to IDLE.
  - For HOLD_CYCLES=4: strobe at cycle T, cmd_ready high again at T+4.
- Change bit:
  - Set only in the first word carrying a new direction.
  - Stop words and same-direction updates carry change=0.
- Speed 0 with a direction change: emitted directly with change=1, no stop insertion.
- word_strobe is never high two consecutive cycles. word_out changes only on strobe cycles or reset.
- Reset mid-STOP or mid-HOLD: on that edge all outputs take reset values. The latched command is discarded and no further word is emitted.
- Counter width is $clog2(max(HOLD_CYCLES,STOP_CYCLES)+1). The counter saturates and never wraps.

Decomposition:
- motor_pkg holds:
  - DATA_W default and word width.
  - Bit positions DIR_BIT=12, CHG_BIT=11.
  - State enum (IDLE, STOP, HOLD).
  - A pack_word(dir, chg, speed) function, shared with the motor register bench.
- One sub-module, motor_hold_timer: a loadable down-counter with a done flag, used by both STOP and HOLD.

Test Plan:
1. Reset held 3 cycles -> word_out=0, word_strobe=0, cmd_ready=0 during reset; cmd_ready=1 on the first cycle after release.
2. After reset, cmd dir=1, speed=11'b10101000101 -> next cycle word_out=13'b1110101000101 and one-cycle strobe; cmd_ready low for 4 cycles.
3. Then dir=1, speed=11'h100 -> word_out=13'b1000100000000 (change=0), single strobe.
4. Then dir=0, speed=11'b10101000101:
   - Stop word 13'b1000000000000 held 8 cycles.
   - Then 13'b0110101000101; exactly two strobes.
   - cmd_ready returns 4 cycles after the second strobe.
5. Repeat the identical last command -> accepted (cmd_ready stays 1), no strobe, word_out unchanged.
6. Assert reset on the 3rd cycle of STOP -> word_out=0, busy=0 next cycle; no post-stop word ever appears.
